// File: rtl/led_pkg.sv
// Shared types and constants for the 7-segment display controller.
package led_pkg;

  typedef logic [4:0] dig_t;      // {dot, hex[3:0]}
  typedef logic [2:0] dig_idx_t;

  localparam dig_t DIG_RESET = 5'h18;
  localparam int   N_DIG     = 8;

  typedef enum logic [0:0] {
    S_SHOW  = 1'b0,
    S_BLANK = 1'b1
  } scan_st_e;

  function automatic dig_idx_t next_idx(input dig_idx_t i);
    return i + 3'd1;
  endfunction

endpackage

// File: rtl/led_rr_arb.sv
// Round-robin arbiter: one-hot combinational grant, priority rotates past the last winner.
module led_rr_arb #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_valid,
  output logic [N-1:0] o_grant
);

  // Requesters at or above the current priority position.
  logic [N-1:0] r_prio_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_pick_hi;
  logic [N-1:0] w_pick_any;
  logic [N-1:0] w_above;

  assign w_hi       = i_valid & r_prio_mask;
  assign w_pick_hi  = w_hi & (~w_hi + N'(1'b1));
  assign w_pick_any = i_valid & (~i_valid + N'(1'b1));
  assign o_grant    = (|w_hi) ? w_pick_hi : w_pick_any;

  // Bits strictly above the granted one; empty means wrap back to requester 0.
  assign w_above = ~(o_grant | (o_grant - N'(1'b1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio_mask <= '1;
    end else if (|o_grant) begin
      r_prio_mask <= (|w_above) ? w_above : '1;
    end
  end

endmodule

// File: rtl/led_disp_ctrl.sv
// 8-digit display controller: shared shadow-buffer writes, frame commit, digit scan.
// Optional inter-digit blanking is enabled by defining LED_BLANK_EN.
module led_disp_ctrl
  import led_pkg::*;
#(
  parameter int F_CLK     = 50000000,
  parameter int F_SCAN    = 1000,
  parameter int N_REQ     = 2,
  parameter int BLANK_CYC = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [3*N_REQ-1:0] i_req_addr,
  input  logic [5*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [2:0]         o_cs_pointer,
  output logic [4:0]         o_dig_ctrl,
  output logic               o_blank,
  output logic               o_frame_tick
);

  localparam int P  = F_CLK / F_SCAN;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
`ifdef LED_BLANK_EN
  localparam int SHOW_CYC = P - BLANK_CYC;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
`else
  localparam int SHOW_CYC = P;
`endif
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYC - 1);

  logic [N_REQ-1:0] w_grant;

  led_rr_arb #(.N(N_REQ)) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_req_valid),
    .o_grant (w_grant)
  );

  assign o_req_ready = w_grant;

  // Grant is one-hot, so an OR chain acts as the write mux.
  dig_idx_t w_addr_chain [N_REQ+1];
  dig_t     w_data_chain [N_REQ+1];

  assign w_addr_chain[0] = '0;
  assign w_data_chain[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req_mux
      assign w_addr_chain[gi+1] = w_addr_chain[gi] | ({3{w_grant[gi]}} & i_req_addr[3*gi +: 3]);
      assign w_data_chain[gi+1] = w_data_chain[gi] | ({5{w_grant[gi]}} & i_req_data[5*gi +: 5]);
    end
  endgenerate

  logic     w_wr_en;
  dig_idx_t w_wr_addr;
  dig_t     w_wr_data;

  assign w_wr_en   = |w_grant;
  assign w_wr_addr = w_addr_chain[N_REQ];
  assign w_wr_data = w_data_chain[N_REQ];

  scan_st_e      r_state;
  logic [CW-1:0] r_cnt;
  dig_idx_t      r_ptr;
  dig_t          r_dig;
  logic          r_tick;

  logic     w_step;
  logic     w_wrap;
  dig_idx_t w_ptr_next;

  assign w_step     = (r_state == S_SHOW) && (r_cnt == SHOW_LAST);
  assign w_wrap     = w_step && (r_ptr == dig_idx_t'(N_DIG - 1));
  assign w_ptr_next = next_idx(r_ptr);

  dig_t r_shadow [N_DIG];
  dig_t r_active [N_DIG];

  generate
    for (gi = 0; gi < N_DIG; gi++) begin : g_buf
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_shadow[gi] <= DIG_RESET;
        end else if (w_wr_en && (w_wr_addr == dig_idx_t'(gi))) begin
          r_shadow[gi] <= w_wr_data;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_active[gi] <= DIG_RESET;
        end else if (w_wrap) begin
          r_active[gi] <= r_shadow[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_state <= S_SHOW;
    end else begin
      case (r_state)
        S_SHOW: begin
          if (w_step) begin
            r_cnt <= '0;
`ifdef LED_BLANK_EN
            r_state <= S_BLANK;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef LED_BLANK_EN
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_cnt   <= '0;
            r_state <= S_SHOW;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        default: begin
          r_cnt   <= '0;
          r_state <= S_SHOW;
        end
      endcase
    end
  end

  // On wrap the active buffer is being loaded this edge, so read through from shadow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr  <= '0;
      r_dig  <= DIG_RESET;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (w_step) begin
        r_ptr <= w_ptr_next;
        r_dig <= w_wrap ? r_shadow[w_ptr_next] : r_active[w_ptr_next];
      end
    end
  end

  assign o_cs_pointer = r_ptr;
  assign o_dig_ctrl   = r_dig;
  assign o_frame_tick = r_tick;

`ifdef LED_BLANK_EN
  assign o_blank = (r_state == S_BLANK);
`else
  assign o_blank = 1'b0;
`endif

endmodule

// File: tb/tb_led_disp_ctrl.sv
// Self-checking bench for led_disp_ctrl (P=10, BLANK_CYC=2, two requesters).
module tb_led_disp_ctrl;

  localparam int P     = 10;
  localparam int NR    = 2;
  localparam int BLK   = 2;
  localparam int FRAME = 8 * P;
`ifdef LED_BLANK_EN
  localparam int OFF       = BLK;
  localparam int EXP_BLANK = 16;
`else
  localparam int OFF       = 0;
  localparam int EXP_BLANK = 0;
`endif

  bit              clk;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [3*NR-1:0] req_addr = '0;
  logic [5*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic [2:0]      cs_pointer;
  logic [4:0]      dig_ctrl;
  logic            blank;
  logic            frame_tick;

  always #5 clk = ~clk;

  led_disp_ctrl #(
    .F_CLK(100), .F_SCAN(10), .N_REQ(NR), .BLANK_CYC(BLK)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_cs_pointer (cs_pointer),
    .o_dig_ctrl   (dig_ctrl),
    .o_blank      (blank),
    .o_frame_tick (frame_tick)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: edge count since reset, last winner, shadow and displayed-frame contents.
  int         m_c = 0;
  int         m_last = NR - 1;
  logic [4:0] m_shadow [8] = '{default: 5'h18};
  logic [4:0] m_active [8] = '{default: 5'h18};

  function automatic logic [NR-1:0] exp_grant(input logic [NR-1:0] v, input int last);
    logic [NR-1:0] g;
    g = '0;
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) begin
        g[(last + k) % NR] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [NR-1:0] g;
    logic [4:0]    snap [8];
    if (!rst_n) begin
      m_c    = 0;
      m_last = NR - 1;
      for (int k = 0; k < 8; k++) begin
        m_shadow[k] = 5'h18;
        m_active[k] = 5'h18;
      end
    end else begin
      snap = m_shadow;
      g = exp_grant(req_valid, m_last);
      for (int r = 0; r < NR; r++) begin
        if (g[r]) begin
          m_shadow[req_addr[3*r +: 3]] = req_data[5*r +: 5];
          m_last = r;
        end
      end
      m_c++;
      if ((m_c + OFF) % FRAME == 0) m_active = snap;
    end
  end

  always @(negedge clk) begin
    int ep;
    ep = ((m_c + OFF) / P) % 8;
    chk("cyc_ptr", int'(cs_pointer), ep);
    chk("cyc_dig", int'(dig_ctrl), int'(m_active[ep]));
    chk("cyc_blank", int'(blank), int'(((m_c + OFF) % P) < OFF));
    chk("cyc_tick", int'(frame_tick), int'(m_c > 0 && ((m_c + OFF) % FRAME) == 0));
    chk("cyc_ready", int'(req_ready), int'(exp_grant(req_valid, m_last)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ptr(input int p, input string nm);
    int k;
    k = 0;
    while (int'(cs_pointer) != p && k < 400) begin
      tick();
      k++;
    end
    chk(nm, int'(cs_pointer), p);
  endtask

  initial begin
    int k;
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ptr", int'(cs_pointer), 0);
    chk("rst_dig", int'(dig_ctrl), 'h18);
    chk("rst_blank", int'(blank), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_ready", int'(req_ready), 0);
    rst_n = 1'b1;

    // 1: idle scan, first frame tick after one frame
    k = 0;
    while (!frame_tick && k < 200) begin
      tick();
      k++;
    end
    chk("t1_first_tick_cycles", k, FRAME - OFF);
    chk("t1_wrap_ptr", int'(cs_pointer), 0);
    chk("t1_wrap_dig", int'(dig_ctrl), 'h18);

    // 2: mid-frame write shows only from the next frame
    repeat (5) tick();
    req_valid = 2'b01;
    req_addr  = {3'd0, 3'd3};
    req_data  = {5'h00, 5'h0A};
    #1;
    chk("t2_ready", int'(req_ready), 'b01);
    tick();
    req_valid = '0;
    wait_ptr(3, "t2_wait3a");
    chk("t2_same_frame", int'(dig_ctrl), 'h18);
    wait_ptr(4, "t2_wait4");
    wait_ptr(3, "t2_wait3b");
    chk("t2_next_frame", int'(dig_ctrl), 'h0A);

    // 3: both requesters hold valid, grants alternate
    req_valid = 2'b11;
    req_addr  = {3'd6, 3'd5};
    req_data  = {5'h1C, 5'h07};
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_grant", int'(req_ready), (i % 2 == 0) ? 'b10 : 'b01);
      chk("t3_onehot", $countones(req_ready), 1);
      tick();
    end
    req_valid = '0;

    // 4: write on the wrap edge lands one frame later
    k = 0;
    while (((m_c + 1 + OFF) % FRAME) != 0 && k < 200) begin
      tick();
      k++;
    end
    req_valid = 2'b01;
    req_addr  = {3'd0, 3'd0};
    req_data  = {5'h00, 5'h05};
    #1;
    chk("t4_ready", int'(req_ready), 'b01);
    tick();
    req_valid = '0;
    chk("t4_tick", int'(frame_tick), 1);
    chk("t4_ptr", int'(cs_pointer), 0);
    chk("t4_old", int'(dig_ctrl), 'h18);
    wait_ptr(5, "t4_wait5");
    chk("t4_d5", int'(dig_ctrl), 'h07);
    wait_ptr(6, "t4_wait6");
    chk("t4_d6", int'(dig_ctrl), 'h1C);
    wait_ptr(7, "t4_wait7");
    wait_ptr(0, "t4_wait0");
    chk("t4_new", int'(dig_ctrl), 'h05);

    // 5: blanking duty over one frame
    cnt = 0;
    repeat (FRAME) begin
      tick();
      cnt += int'(blank);
    end
    chk("t5_blank_per_frame", cnt, EXP_BLANK);

    // 6: async reset mid-frame discards buffered writes
    req_valid = 2'b10;
    req_addr  = {3'd2, 3'd0};
    req_data  = {5'h13, 5'h00};
    #1;
    chk("t6_ready", int'(req_ready), 'b10);
    tick();
    req_valid = '0;
    repeat (13) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ptr", int'(cs_pointer), 0);
    chk("t6_rst_dig", int'(dig_ctrl), 'h18);
    chk("t6_rst_blank", int'(blank), 0);
    chk("t6_rst_tick", int'(frame_tick), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ptr(2, "t6_wait2");
    chk("t6_d2", int'(dig_ctrl), 'h18);
    wait_ptr(3, "t6_wait3");
    chk("t6_d3", int'(dig_ctrl), 'h18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
